// File: rtl/sram_mem_controller_if.sv
// Pipeline-side MEM-stage request/response bundle for the SRAM controller.
// The CPU (master) drives the request, the controller (slave) returns data and the freeze control.
interface sram_mem_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_mem_controller.sv
// MEM-stage load/store against a 16-bit async SRAM, one word as two WAIT_CYCLES-long half accesses.
// Latency 2*WAIT_CYCLES+1 cycles from request to ready; ready=0 freezes the pipeline meanwhile.
module sram_mem_controller #(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_mem_controller_if.slave   cpu,
    output logic [SRAM_AW-1:0]     sram_addr,
    inout  wire  [15:0]            sram_dq,
    output logic                   sram_we_n
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          op_wr;
    logic [31:0]   wdata;
    logic [31:0]   read_data_q;
    logic          req;
    logic          last;
    logic          drive;
    logic [15:0]   dq_out;
    logic [31:0]   diff;
    logic          addr_unused;

    assign req  = cpu.wr_en | cpu.rd_en;
    assign last = (cnt == CW'(WAIT_CYCLES - 1));

    // Only the word-index bits that fit the SRAM are used; the rest wrap away.
    assign diff        = cpu.address - BASE_ADDR;
    assign addr_unused = ^{diff[31:SRAM_AW+1], diff[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                end
            end
            LO: begin
                if (last) begin
                    state_nxt = HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HI: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            wdata       <= '0;
            read_data_q <= '0;
            sram_addr   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                op_wr     <= cpu.wr_en;
                wdata     <= cpu.write_data;
                sram_addr <= {diff[SRAM_AW:2], 1'b0};
            end
            if (state == LO && last) begin
                sram_addr[0] <= 1'b1;
                if (!op_wr) read_data_q[15:0] <= sram_dq;
            end
            if (state == HI && last && !op_wr) begin
                read_data_q[31:16] <= sram_dq;
            end
        end
    end

    // Write strobe is purely state-derived so an async reset drops it immediately.
    assign drive     = op_wr && (state == LO || state == HI);
    assign sram_we_n = ~drive;
    assign dq_out    = (state == HI) ? wdata[31:16] : wdata[15:0];
    assign sram_dq   = drive ? dq_out : 16'hzzzz;

    assign cpu.read_data = read_data_q;
    assign cpu.ready     = ((state == IDLE) && !req) || (state == DONE);
endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed cases plus random loads/stores against a word-level model.
module tb_sram_mem_controller;
    localparam int          WAIT     = 5;
    localparam logic [31:0] BASE     = 32'd1024;
    localparam int          AW       = 18;
    localparam int          LAT_LOW  = 2 * WAIT + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [AW-1:0] sram_addr;
    wire  [15:0]   sram_dq;
    logic          sram_we_n;

    sram_mem_controller_if bus ();

    sram_mem_controller #(.WAIT_CYCLES(WAIT), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .cpu(bus), .sram_addr(sram_addr),
        .sram_dq(sram_dq), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // Async SRAM model: reads whenever we_n is high; a write sticks only if the
    // strobe stays low on one address for the full access time.
    logic [15:0] sram [0:(1<<AW)-1];
    int          wrun = 0;
    logic [AW-1:0] wadr = '0;
    assign sram_dq = sram_we_n ? sram[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        int nrun;
        if (sram_we_n) begin
            wrun = 0;
        end else begin
            nrun = (wrun != 0 && sram_addr == wadr) ? wrun + 1 : 1;
            if (nrun == WAIT) sram[sram_addr] = sram_dq;
            wrun = nrun;
            wadr = sram_addr;
        end
    end

    // Reference model: half-word contents and the architectural read_data.
    logic [15:0] ref_half [int];
    logic [31:0] ref_rd = '0;
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return int'((d >> 2) & ((32'd1 << (AW - 1)) - 1));
    endfunction

    function automatic logic [15:0] ref_get(input int h);
        return ref_half.exists(h) ? ref_half[h] : 16'h0;
    endfunction

    // Monitor: a completion is ready=1 while a request is still asserted.
    int lowcnt = 0;
    int n_done = 0;
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                lowcnt = 0;
            end else if ((bus.wr_en | bus.rd_en) && !bus.ready) begin
                lowcnt++;
            end else if ((bus.wr_en | bus.rd_en) && bus.ready) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("read_data", bus.read_data, e);
                    chk("latency", 32'(lowcnt), 32'(LAT_LOW));
                end
                lowcnt = 0;
            end else begin
                lowcnt = 0;
            end
        end
    end

    task automatic set_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        bus.wr_en = w; bus.rd_en = r; bus.address = a; bus.write_data = d;
    endtask

    task automatic idle(input int n);
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Issues one access (held until ready), optionally scrambling inputs mid-flight.
    task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                          input bit scramble);
        int wi;
        bit got;
        wi = word_of(a);
        if (w) begin
            exp_q.push_back(ref_rd);
            ref_half[2*wi]   = d[15:0];
            ref_half[2*wi+1] = d[31:16];
        end else begin
            ref_rd = {ref_get(2*wi+1), ref_get(2*wi)};
            exp_q.push_back(ref_rd);
        end
        set_req(w, r, a, d);
        got = 1'b0;
        for (int c = 0; c < 4 * LAT_LOW && !got; c++) begin
            @(negedge clk);
            if (bus.ready && c > 0) got = 1'b1;
            if (scramble && c == 3) begin
                bus.wr_en = $urandom_range(0, 1);
                bus.rd_en = ~bus.wr_en;
                bus.address = $urandom;
                bus.write_data = $urandom;
            end
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int op;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_ready", 32'(bus.ready), 32'd1);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk); #1;

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
        idle(2);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        idle(1);
        access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        idle(2);
        chk("sram0", 32'(sram[0]), 32'h0000BEEF);
        chk("sram1", 32'(sram[1]), 32'h0000DEAD);
        chk("sram2", 32'(sram[2]), 32'h00005678);
        chk("sram3", 32'(sram[3]), 32'h00001234);

        // Reset in cycle 7 of a write: low half already committed, high half abandoned.
        set_req(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D);
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        bus.wr_en = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_read_data", bus.read_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        ref_half[4] = 16'hF00D;
        ref_rd = 32'h0;
        idle(2);
        chk("abort_sram5", 32'(sram[5]), 32'h0);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        access(1'b1, 1'b1, 32'd1036, 32'hA5A50F0F, 1'b0);
        idle(1);
        chk("both_sram6", 32'(sram[6]), 32'h00000F0F);
        chk("both_sram7", 32'(sram[7]), 32'h0000A5A5);

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 5);
            a  = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + (32'd1 << (AW + 1));
            if ($urandom_range(0, 7) == 0) a = BASE - 32'd4;
            d  = $urandom;
            access(op < 2, op >= 1, a, d, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        foreach (ref_half[h]) chk("final_sram", 32'(sram[h]), 32'(ref_half[h]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
